// File: rtl/dmem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_lsu : byte-addressed data memory with RISC-V load/store sizing, fixed-latency response
// Revision : 1.0
// ---------------------------------------------------------------------------
module dmem_lsu #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [2:0] CNT_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        illegal, misalign, oob, fault;
  logic [1:0]  size_m1;
  logic [32:0] last_byte;

  logic [AW-1:0] addr_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic          err_q;

  logic [AW-1:0] sel_addr;
  logic [2:0]    sel_f3;
  logic          sel_we;
  logic          sel_err;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   ld_ext;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready & rst_n;

  // Access checks on the live request; the 33-bit sum keeps high addresses from wrapping
  always_comb begin
    size_m1 = 2'd0;
    case (req_funct3[1:0])
      2'b00:   size_m1 = 2'd0;
      2'b01:   size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    if (req_we)
      illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    last_byte = {1'b0, req_addr} + {31'd0, size_m1};
    oob       = (last_byte >= 33'(DEPTH));
    fault     = illegal | misalign | oob;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ZERO_LAT) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 3'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state_nx == RESP) && (state != RESP);

  // With zero latency the response is formed from the request still on the inputs
  assign sel_addr = (state == IDLE) ? req_addr[AW-1:0] : addr_q;
  assign sel_f3   = (state == IDLE) ? req_funct3 : funct3_q;
  assign sel_we   = (state == IDLE) ? req_we : we_q;
  assign sel_err  = (state == IDLE) ? fault : err_q;

  assign b0 = mem[sel_addr];
  assign b1 = mem[sel_addr + AW'(1)];
  assign b2 = mem[sel_addr + AW'(2)];
  assign b3 = mem[sel_addr + AW'(3)];

  always_comb begin
    ld_ext = 32'd0;
    case (sel_f3)
      3'b000:  ld_ext = {{24{b0[7]}}, b0};
      3'b001:  ld_ext = {{16{b1[7]}}, b1, b0};
      3'b010:  ld_ext = {b3, b2, b1, b0};
      3'b100:  ld_ext = {24'd0, b0};
      3'b101:  ld_ext = {16'd0, b1, b0};
      default: ld_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      addr_q    <= '0;
      funct3_q  <= 3'd0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q   <= req_addr[AW-1:0];
        funct3_q <= req_funct3;
        we_q     <= req_we;
        err_q    <= fault;
      end
      if (enter_resp) begin
        rsp_rdata <= (sel_err || sel_we) ? 32'd0 : ld_ext;
        rsp_err   <= sel_err;
      end
    end
  end

  // Memory is outside the reset domain so contents survive rst_n
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      mem[req_addr[AW-1:0]] <= req_wdata[7:0];
      if (req_funct3[1:0] != 2'b00)
        mem[req_addr[AW-1:0] + AW'(1)] <= req_wdata[15:8];
      if (req_funct3[1:0] == 2'b10) begin
        mem[req_addr[AW-1:0] + AW'(2)] <= req_wdata[23:16];
        mem[req_addr[AW-1:0] + AW'(3)] <= req_wdata[31:24];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_lsu : three dmem_lsu instances (LATENCY 1, 0, 3) checked against a byte-array model
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  logic        clk = 1'b0;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [2:0]  req_funct3[NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  logic [7:0]  model_mem [NI][DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_lsu #(
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: legality table, natural alignment, no-wrap bound, little-endian bytes
  task automatic ref_access(input int k, input bit we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output bit err, output logic [31:0] rd);
    bit          legal;
    int          size;
    longint      last;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    size  = 1 << f3[1:0];
    last  = longint'({32'd0, a}) + longint'(size) - 1;
    err   = !legal || ((a % size) != 0) || (last >= DEPTH);
    rd    = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) model_mem[k][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = model_mem[k][int'(a) + i];
        case (f3)
          3'b000:  rd = {{24{v[7]}}, v[7:0]};
          3'b001:  rd = {{16{v[15]}}, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endtask

  task automatic txn(input int k, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          n;
    ref_access(k, we, f3, a, wd, exp_err, exp_rd);
    @(negedge clk);
    req_we[k] = we; req_funct3[k] = f3; req_addr[k] = a; req_wdata[k] = wd;
    req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
    check("ready_wait", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[k] && n < 20);
    check("rsp_latency", n, lat_of(k) + 1);
    got = rsp_rdata[k];
    check("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
    check("rsp_rdata", got, exp_rd);
    @(negedge clk);
    check("rsp_single", 32'(rsp_valid[k]), 32'd0);
    check("rsp_hold", rsp_rdata[k], exp_rd);
  endtask

  task automatic dir(input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp);
    logic [31:0] got;
    txn(0, we, f3, a, wd, got);
    check("directed", got, exp);
  endtask

  initial begin
    logic [31:0] got, a;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int          acc [3];
    int          na, cyc, seen;
    bit          e;
    logic [31:0] r;

    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_funct3[k] = 3'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
      for (int i = 0; i < DEPTH; i++) model_mem[k][i] = 8'h00;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_ready", 32'(req_ready[k]), 32'd1);
      check("rst_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_rdata", rsp_rdata[k], 32'd0);
      check("rst_err", 32'(rsp_err[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    // Directed sequence on the LATENCY=1 instance
    dir(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0);
    dir(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF);
    dir(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE);
    dir(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE);
    dir(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF);
    dir(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD);
    dir(1'b1, 3'b000, 32'h11, 32'h12345678, 32'h0);
    dir(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD78EF);
    dir(1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h0);
    dir(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE78EF);
    dir(1'b0, 3'b010, 32'h11, 32'h0, 32'h0);
    dir(1'b0, 3'b001, 32'h13, 32'h0, 32'h0);
    dir(1'b1, 3'b010, DEPTH - 2, 32'hFFFFFFFF, 32'h0);
    dir(1'b0, 3'b011, 32'h10, 32'h0, 32'h0);
    dir(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE78EF);
    dir(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0);

    // Back-to-back stores with req_valid held high on the LATENCY=0 instance
    for (int i = 0; i < 3; i++) begin
      b2b_addr[i] = 32'h40 + 32'(4 * i);
      b2b_data[i] = $urandom;
    end
    @(negedge clk);
    req_we[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = b2b_addr[0]; req_wdata[1] = b2b_data[0]; req_valid[1] = 1'b1;
    na = 0; cyc = 0;
    while (na < 3 && cyc < 20) begin
      if (req_ready[1]) begin
        acc[na] = cyc;
        ref_access(1, 1'b1, 3'b010, b2b_addr[na], b2b_data[na], e, r);
        na++;
        @(posedge clk);
        #1;
        if (na < 3) begin
          req_addr[1] = b2b_addr[na]; req_wdata[1] = b2b_data[na];
        end else begin
          req_valid[1] = 1'b0;
        end
      end else begin
        check("b2b_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        check("b2b_rsp_err", 32'(rsp_err[1]), 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_accepts", na, 3);
    check("b2b_gap1", acc[1] - acc[0], 2);
    check("b2b_gap2", acc[2] - acc[1], 2);
    for (int i = 0; i < 3; i++) txn(1, 1'b0, 3'b010, b2b_addr[i], 32'h0, got);

    // Reset during WAIT on the LATENCY=3 instance
    txn(2, 1'b1, 3'b010, 32'h20, 32'h11223344, got);
    txn(2, 1'b0, 3'b010, 32'h20, 32'h0, got);
    @(negedge clk);
    req_we[2] = 1'b1; req_funct3[2] = 3'b010; req_addr[2] = 32'h24;
    req_wdata[2] = 32'hA5A5A5A5; req_valid[2] = 1'b1;
    ref_access(2, 1'b1, 3'b010, 32'h24, 32'hA5A5A5A5, e, r);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready[2]), 32'd1);
    check("abort_valid", 32'(rsp_valid[2]), 32'd0);
    check("abort_rdata", rsp_rdata[2], 32'd0);
    check("abort_err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen++;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_ready_after", 32'(req_ready[2]), 32'd1);
    txn(2, 1'b0, 3'b010, 32'h20, 32'h0, got);
    txn(2, 1'b0, 3'b010, 32'h24, 32'h0, got);

    // Randomized traffic on every instance
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 120; i++) begin
        case ($urandom_range(0, 3))
          0:       a = 32'($urandom_range(0, 63));
          1:       a = 32'(DEPTH - 8 + $urandom_range(0, 15));
          2:       a = $urandom;
          default: a = 32'($urandom_range(0, DEPTH - 1)) & ~32'h3;
        endcase
        txn(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
